// File: rtl/cpu_defs.sv
// Shared CPU type definitions: data word, register address and the
// execute-stage operation codes consumed by the memory access unit.
package cpu_defs;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ALU = 4'd1,
    OP_LB  = 4'd2,
    OP_LH  = 4'd3,
    OP_LW  = 4'd4,
    OP_LBU = 4'd5,
    OP_LHU = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } oper_t;

  function automatic logic is_load(input oper_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input oper_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input oper_t op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input oper_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus between the memory access unit (master) and memory (slave).
//   bus_req   request, held until the ack cycle
//   bus_we    1 = write
//   bus_addr  word-aligned address
//   bus_be    byte enables
//   bus_wdata lane-replicated write data
//   bus_ack   slave completes the access
//   bus_rdata read data, valid with bus_ack
interface mem_access_unit_if;
  import cpu_defs::*;

  logic       bus_req;
  logic       bus_we;
  word_t      bus_addr;
  logic [3:0] bus_be;
  word_t      bus_wdata;
  logic       bus_ack;
  word_t      bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for sub-word accesses.
//   op, addr_lo : access type and low address bits
//   wdata       : store source value; wdata_lane is it replicated into lanes
//   rdata       : raw bus read data; load_data is the selected lane extended
//   be          : byte enables (same for loads and stores of one width)
module mem_lane_align
  import cpu_defs::*;
(
  input  oper_t      op,
  input  logic [1:0] addr_lo,
  input  word_t      wdata,
  input  word_t      rdata,
  output logic [3:0] be,
  output word_t      wdata_lane,
  output word_t      load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    load_data  = rdata;
    case (op)
      OP_SB, OP_LB, OP_LBU: be = 4'b0001 << addr_lo;
      OP_SH, OP_LH, OP_LHU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      OP_SW, OP_LW:         be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    case (op)
      OP_SB:   wdata_lane = {4{wdata[7:0]}};
      OP_SH:   wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase
    case (op)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns EX load/store ops into single bus transactions and
// forwards non-memory results to writeback.
//   clk, rst      : clock, asynchronous active-high reset
//   ex_*          : operation from EX (held by the pipeline under stall_req)
//   bus           : mem_access_unit_if master port
//   wb_*          : writeback result, one-cycle valid
//   stall_req     : hold the pipeline while a memory access is outstanding
//   bus_err       : one-cycle pulse when an access times out
//   misalign_exc  : one-cycle pulse on a misaligned access
// Build option: MISALIGN_TRAP_EN -- trap misaligned halfword/word accesses
// instead of forcing the address down to alignment.
//
// state  | meaning
// IDLE   | accept a new op; non-memory ops retire here in one cycle
// ACCESS | bus_req held with registered outputs until ack or timeout
module mem_access_unit
  import cpu_defs::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ex_valid,
  input  oper_t    ex_op,
  input  word_t    ex_addr,
  input  word_t    ex_wdata,
  input  regaddr_t ex_rd,
  mem_access_unit_if.master bus,
  output logic     wb_valid,
  output logic     wb_we,
  output regaddr_t wb_rd,
  output word_t    wb_data,
  output logic     stall_req,
  output logic     bus_err,
  output logic     misalign_exc
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  oper_t            op_q;
  logic [1:0]       addr_lo_q;
  regaddr_t         rd_q;
  logic             bus_we_q;
  word_t            bus_addr_q;
  logic [3:0]       bus_be_q;
  word_t            bus_wdata_q;
  logic             wb_valid_q, wb_we_q, bus_err_q;
  regaddr_t         wb_rd_q;
  word_t            wb_data_q;

  word_t      ex_addr_al;
  logic       mem_op, legal, accept, in_access, timeout_hit;
  oper_t      la_op;
  logic [1:0] la_addr_lo;
  logic [3:0] la_be;
  word_t      la_wdata, la_load;

  assign mem_op = is_load(ex_op) || is_store(ex_op);

  // Misaligned addresses are forced down; with the trap enabled they never
  // reach the bus, so the forced value is only used for legal accesses.
  always_comb begin
    ex_addr_al = ex_addr;
    if (is_half(ex_op)) ex_addr_al[0] = 1'b0;
    if (is_word(ex_op)) ex_addr_al[1:0] = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned, misalign_q;
  assign misaligned = (is_half(ex_op) && ex_addr[0]) ||
                      (is_word(ex_op) && (ex_addr[1:0] != 2'b00));
  assign legal = mem_op && !misaligned;
`else
  assign legal = mem_op;
`endif

  assign in_access   = (state == ACCESS);
  assign accept      = (state == IDLE) && ex_valid && legal;
  assign timeout_hit = in_access && !bus.bus_ack && (cnt == CNT_LAST);

  // One aligner serves both directions: EX fields while idle (to latch be
  // and wdata on entry), registered fields while accessing (load extend).
  assign la_op      = in_access ? op_q : ex_op;
  assign la_addr_lo = in_access ? addr_lo_q : ex_addr_al[1:0];

  mem_lane_align u_lane_align (
    .op         (la_op),
    .addr_lo    (la_addr_lo),
    .wdata      (ex_wdata),
    .rdata      (bus.bus_rdata),
    .be         (la_be),
    .wdata_lane (la_wdata),
    .load_data  (la_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (bus.bus_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= OP_NOP;
      addr_lo_q   <= 2'b00;
      rd_q        <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          cnt         <= '0;
          op_q        <= ex_op;
          addr_lo_q   <= ex_addr_al[1:0];
          rd_q        <= ex_rd;
          bus_we_q    <= is_store(ex_op);
          bus_addr_q  <= {ex_addr_al[31:2], 2'b00};
          bus_be_q    <= la_be;
          bus_wdata_q <= la_wdata;
        end else if (ex_valid && (ex_op != OP_NOP) && !mem_op) begin
          wb_valid_q <= 1'b1;
          wb_we_q    <= (ex_rd != '0);
          wb_rd_q    <= ex_rd;
          wb_data_q  <= ex_addr;
        end
      end else begin
        if (bus.bus_ack) begin
          bus_we_q   <= 1'b0;
          wb_valid_q <= 1'b1;
          wb_rd_q    <= rd_q;
          if (is_load(op_q)) begin
            wb_we_q   <= (rd_q != '0);
            wb_data_q <= la_load;
          end else begin
            wb_data_q <= '0;
          end
        end else if (timeout_hit) begin
          bus_we_q  <= 1'b0;
          bus_err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state == IDLE) && ex_valid && mem_op && misaligned;
  end
  assign misalign_exc = misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

  // bus_req follows the state register so reset drops it without a clock.
  assign bus.bus_req   = in_access;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

  assign stall_req = !rst && (accept || (in_access && !bus.bus_ack));

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  import cpu_defs::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     ex_valid = 1'b0;
  oper_t    ex_op = OP_NOP;
  word_t    ex_addr = '0;
  word_t    ex_wdata = '0;
  regaddr_t ex_rd = '0;
  logic     wb_valid, wb_we, stall_req, bus_err, misalign_exc;
  regaddr_t wb_rd;
  word_t    wb_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.BUS_TIMEOUT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .bus          (bus),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall_req    (stall_req),
    .bus_err      (bus_err),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input oper_t op, input word_t addr, input word_t wd, input regaddr_t rd);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wd;
    ex_rd    = rd;
  endtask

  // Full memory access: accept, wait_n extra ACCESS cycles, ack, check WB.
  task automatic run_mem(input string tag, input oper_t op, input word_t addr,
                         input word_t wd, input regaddr_t rd, input word_t rdata,
                         input int wait_n, input word_t e_addr, input logic [3:0] e_be,
                         input word_t e_wdata, input logic e_we,
                         input logic e_wb_we, input word_t e_wb_data);
    drive(op, addr, wd, rd);
    #1;
    check({tag, ".stall_idle"}, stall_req, 1);
    tick();
    // EX inputs must be ignored while the access is outstanding.
    drive(OP_SB, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 5'd31);
    #1;
    check({tag, ".req"}, bus.bus_req, 1);
    check({tag, ".addr"}, bus.bus_addr, e_addr);
    check({tag, ".be"}, bus.bus_be, e_be);
    check({tag, ".wdata"}, bus.bus_wdata, e_wdata);
    check({tag, ".we"}, bus.bus_we, e_we);
    check({tag, ".stall_acc"}, stall_req, 1);
    repeat (wait_n) tick();
    check({tag, ".addr_hold"}, bus.bus_addr, e_addr);
    check({tag, ".be_hold"}, bus.bus_be, e_be);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = rdata;
    #1;
    check({tag, ".stall_ack"}, stall_req, 0);
    tick();
    ex_valid    = 1'b0;
    bus.bus_ack = 1'b0;
    #1;
    check({tag, ".wb_valid"}, wb_valid, 1);
    check({tag, ".wb_we"}, wb_we, e_wb_we);
    check({tag, ".wb_data"}, wb_data, e_wb_data);
    check({tag, ".wb_rd"}, wb_rd, rd);
    check({tag, ".req_off"}, bus.bus_req, 0);
    check({tag, ".no_err"}, bus_err, 0);
    tick();
    check({tag, ".wb_pulse"}, wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    drive(OP_SW, 32'h0000_1000, 32'h1, 5'd1);
    repeat (3) tick();
    check("rst.stall", stall_req, 0);
    check("rst.req", bus.bus_req, 0);
    check("rst.wb_valid", wb_valid, 0);
    check("rst.addr", bus.bus_addr, 0);
    check("rst.be", bus.bus_be, 0);
    check("rst.err", bus_err, 0);
    check("rst.mis", misalign_exc, 0);

    // First op accepted on the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    drive(OP_ALU, 32'h1234_5678, 32'h0, 5'd3);
    tick();
    check("alu.valid", wb_valid, 1);
    check("alu.data", wb_data, 32'h1234_5678);
    check("alu.rd", wb_rd, 3);
    check("alu.we", wb_we, 1);
    check("alu.req", bus.bus_req, 0);
    check("alu.stall", stall_req, 0);
    drive(OP_ALU, 32'hCAFE_0001, 32'h0, 5'd0);
    tick();
    check("alu0.valid", wb_valid, 1);
    check("alu0.we", wb_we, 0);
    check("alu0.data", wb_data, 32'hCAFE_0001);
    ex_valid = 1'b0;
    tick();
    check("novalid.wb", wb_valid, 0);
    drive(OP_NOP, 32'h1, 32'h0, 5'd4);
    tick();
    check("nop.wb", wb_valid, 0);
    ex_valid = 1'b0;

    // Ack while idle is ignored.
    bus.bus_ack = 1'b1;
    tick();
    check("idle_ack.wb", wb_valid, 0);
    check("idle_ack.req", bus.bus_req, 0);
    bus.bus_ack = 1'b0;
    tick();

    run_mem("sb", OP_SB, 32'h0000_1003, 32'h0000_00A5, 5'd0, 32'h0, 2,
            32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1, 0, 32'h0);
    run_mem("lb", OP_LB, 32'h0000_2001, 32'h0, 5'd5, 32'h0000_8000, 1,
            32'h0000_2000, 4'b0010, 32'h0, 0, 1, 32'hFFFF_FF80);
    run_mem("lbu", OP_LBU, 32'h0000_2001, 32'h0, 5'd5, 32'h0000_8000, 0,
            32'h0000_2000, 4'b0010, 32'h0, 0, 1, 32'h0000_0080);
    run_mem("lh", OP_LH, 32'h0000_3002, 32'h0, 5'd7, 32'h8001_0000, 3,
            32'h0000_3000, 4'b1100, 32'h0, 0, 1, 32'hFFFF_8001);
    run_mem("lhu", OP_LHU, 32'h0000_3000, 32'h0, 5'd8, 32'h0000_F00F, 0,
            32'h0000_3000, 4'b0011, 32'h0, 0, 1, 32'h0000_F00F);
    run_mem("lw_r0", OP_LW, 32'h0000_5000, 32'h0, 5'd0, 32'h1234_5678, 1,
            32'h0000_5000, 4'b1111, 32'h0, 0, 0, 32'h1234_5678);
    run_mem("sh", OP_SH, 32'h0000_6002, 32'h1234_ABCD, 5'd9, 32'h0, 0,
            32'h0000_6000, 4'b1100, 32'hABCD_ABCD, 1, 0, 32'h0);
    run_mem("sw", OP_SW, 32'h0000_7000, 32'hCAFE_F00D, 5'd2, 32'h0, 1,
            32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 1, 0, 32'h0);

    // Timeout: bus_req must stay up exactly 255 cycles.
    drive(OP_SW, 32'h0000_4000, 32'h1111_2222, 5'd1);
    tick();
    ex_valid = 1'b0;
    n = 0;
    while (bus.bus_req && n < 400) begin
      n++;
      if (n < 255 && bus_err) check("to.early_err", bus_err, 0);
      tick();
    end
    check("to.req_cycles", n, 255);
    check("to.err", bus_err, 1);
    check("to.wb_valid", wb_valid, 0);
    check("to.stall", stall_req, 0);
    tick();
    check("to.err_pulse", bus_err, 0);

    // Ack in the final timeout cycle wins.
    run_mem("to_ack", OP_LW, 32'h0000_4100, 32'h0, 5'd6, 32'h0BAD_F00D, 254,
            32'h0000_4100, 4'b1111, 32'h0, 0, 1, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
    drive(OP_SW, 32'h0000_4002, 32'hDEAD_0000, 5'd1);
    #1;
    check("mis.stall", stall_req, 0);
    tick();
    ex_valid = 1'b0;
    check("mis.exc", misalign_exc, 1);
    check("mis.req", bus.bus_req, 0);
    check("mis.wb", wb_valid, 0);
    tick();
    check("mis.pulse", misalign_exc, 0);
    check("mis.req2", bus.bus_req, 0);
`else
    run_mem("mis_sw", OP_SW, 32'h0000_4002, 32'hDEAD_0000, 5'd1, 32'h0, 0,
            32'h0000_4000, 4'b1111, 32'hDEAD_0000, 1, 0, 32'h0);
    run_mem("mis_lh", OP_LH, 32'h0000_3001, 32'h0, 5'd4, 32'h0000_8123, 0,
            32'h0000_3000, 4'b0011, 32'h0, 0, 1, 32'hFFFF_8123);
    check("mis.exc_tied", misalign_exc, 0);
`endif

    // Reset mid-access drops bus_req without a clock edge.
    drive(OP_LW, 32'h0000_8000, 32'h0, 5'd10);
    tick();
    ex_valid = 1'b0;
    check("mid.req_before", bus.bus_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid.req", bus.bus_req, 0);
    check("mid.stall", stall_req, 0);
    check("mid.addr", bus.bus_addr, 0);
    check("mid.be", bus.bus_be, 0);
    @(negedge clk);
    rst = 1'b0;
    run_mem("post_rst_lw", OP_LW, 32'h0000_9004, 32'h0, 5'd11, 32'hA1B2_C3D4, 1,
            32'h0000_9004, 4'b1111, 32'h0, 0, 1, 32'hA1B2_C3D4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: BUS_TIMEOUT, 255, ACCESS-state cycles without bus_ack before the access aborts.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 Port: clk  in  1  system clock, rising edge.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Ports from EX: ex_valid in 1; ex_op in oper_t; ex_addr in word_t (effective address or ALU result); ex_wdata in word_t (rs2 value); ex_rd in regaddr_t.
REQ-006 Ports to bus: bus_req out 1; bus_we out 1; bus_addr out word_t (word-aligned, bits[1:0]=0); bus_be out 4; bus_wdata out word_t; bus_ack in 1; bus_rdata in word_t.
REQ-007 Ports to WB: wb_valid out 1; wb_we out 1; wb_rd out regaddr_t; wb_data out word_t.
REQ-008 Ports to pipeline control: stall_req out 1; bus_err out 1 (one-cycle pulse); misalign_exc out 1 (one-cycle pulse).

Function
REQ-009 FSM states IDLE and ACCESS; IDLE->ACCESS when ex_valid and ex_op is OP_SB/SH/SW/LB/LH/LW/LBU/LHU and the access is legal; ACCESS->IDLE on bus_ack or timeout.
REQ-010 Non-memory valid op in IDLE: next cycle wb_valid=1, wb_data=ex_addr, wb_rd=ex_rd, wb_we=(ex_rd!=0); no bus activity; latency 1.
REQ-011 ex_valid=0 or OP_NOP in IDLE: next cycle wb_valid=0.
REQ-012 On entry to ACCESS: address, be, wdata, we, rd, op registered; bus_req=1 held with all bus outputs stable until the bus_ack cycle.
REQ-013 Stores: SB be=1<<addr[1:0], byte replicated in all four lanes; SH be=0011 (addr[1]=0) or 1100, halfword replicated in both halves; SW be=1111.
REQ-014 Loads: bus_be as for the same-width store, bus_we=0; LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes bus_rdata.
REQ-015 bus_ack in ACCESS: next cycle wb_valid=1; loads wb_we=(rd!=0) with extended data; stores wb_we=0, wb_data=0; bus_req=0 that next cycle.
REQ-016 stall_req combinational: 1 in IDLE when ex_valid and a legal memory op is present, 1 in ACCESS; 0 in the cycle bus_ack is sampled high.
REQ-017 Timeout counter cleared on ACCESS entry, increments each ACCESS cycle without ack; reaching BUS_TIMEOUT: next cycle bus_err=1 one cycle, wb_valid=0, state IDLE, bus_req=0.
REQ-018 bus_ack and timeout in the same cycle: ack wins, no bus_err.
REQ-019 bus_ack sampled in IDLE is ignored.
REQ-020 EX inputs are ignored while in ACCESS; the pipeline holds them under stall_req.

Reset
REQ-021 rst asserted at any time, including mid-ACCESS: state=IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, bus_err=0, misalign_exc=0; stall_req=0 while rst is high.
REQ-022 First access accepted on the first rising edge after rst deasserts.

Configuration
REQ-023 Macro MISALIGN_TRAP_EN defined: halfword op with addr[0]=1, or word op with addr[1:0]!=0, issues no bus request; next cycle misalign_exc=1 one cycle, wb_valid=0; stall_req=0.
REQ-024 MISALIGN_TRAP_EN undefined: misaligned addresses are forced down (halfword &~1, word &~3) and the access proceeds normally; misalign_exc tied 0.

Structure
REQ-025 oper_t, word_t, regaddr_t and all OP_* codes come from the shared cpu_defs header; no local redefinition.
REQ-026 FSM state encoding and BUS_TIMEOUT stay local to the module.
REQ-027 One combinational sub-module, mem_lane_align: computes bus_be, replicated wdata and load extension from op, addr[1:0] and rdata.

Verification
REQ-028 SB addr=0x1003 wdata=0x000000A5 -> bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5; ack after 2 cycles -> wb_valid=1, wb_we=0.
REQ-029 LB addr=0x2001, rdata=0x0000_80_00 (byte1=0x80), rd=5 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 LH addr=0x3002, rdata=0x8001_0000 -> be=1100, wb_data=0xFFFF8001; stall_req high from accept through ack cycle.
REQ-031 SW addr=0x4000, no ack -> bus_req held BUS_TIMEOUT cycles, then bus_err one-cycle pulse, wb_valid=0, IDLE.
REQ-032 SW addr=0x4002 -> with MISALIGN_TRAP_EN: misalign_exc pulse, bus_req never rises; without: bus_addr=0x4000, be=1111.
REQ-033 rst asserted in ACCESS with bus_req=1 -> bus_req=0 immediately without a clock edge; next LW completes normally.
